// File: rtl/sync_debounce.sv
// sync_debounce: multi-flop synchronizer followed by a stability-counter debouncer
// producing a registered level plus single-cycle rise/fall pulses.
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  assign busy = cnt != '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], d_in};
  // any agreement between s and q discards the partial count, so glitches never reach q
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        if (s == q) cnt <= '0;
        else if (cnt == LAST) begin
          q    <= ~q;
          cnt  <= '0;
          rise <= ~q;
          fall <= q;
        end else cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: directed per-cycle vectors pushed to a scoreboard queue, checked by a separate monitor.
module tb_sync_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_in = 1'b1;
  logic en = 1'b1;
  logic q, rise, fall, busy;
  typedef struct {
    logic [3:0] exp;
    int id;
  } item_t;
  item_t sb[$];
  int tests = 0;
  int fails = 0;
  int id = 0;
  bit done = 1'b0;
  event ev_async;
  sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .en(en),
    .q(q), .rise(rise), .fall(fall), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic push(input logic [3:0] exp);
    item_t it;
    it.exp = exp;
    it.id = id;
    id++;
    sb.push_back(it);
  endtask
  // one vector per clock: drive at negedge, expectation {q,rise,fall,busy} after the next posedge
  task automatic row(input logic r, input logic e, input logic d, input logic [3:0] exp);
    @(negedge clk);
    rst = r;
    en = e;
    d_in = d;
    push(exp);
  endtask
  // assert reset between edges; outputs must clear before the next posedge
  task automatic async_rst();
    @(posedge clk);
    #3;
    rst = 1'b1;
    push(4'b0000);
    ->ev_async;
  endtask
  initial begin : monitor
    item_t it;
    logic [3:0] got;
    while (!done) begin
      @(posedge clk or ev_async);
      #1;
      if (sb.size() != 0) begin
        it = sb.pop_front();
        got = {q, rise, fall, busy};
        tests++;
        if (got !== it.exp) begin
          fails++;
          $display("FAIL check %0d: {q,rise,fall,busy} got %b expected %b", it.id, got, it.exp);
        end
      end
    end
  end
  initial begin : stim
    // reset held with d_in=1 and clock running
    row(1, 1, 1, 4'b0000);
    row(1, 1, 1, 4'b0000);
    row(1, 1, 1, 4'b0000);
    row(0, 1, 0, 4'b0000);
    row(0, 1, 0, 4'b0000);
    // clean rise: q at edge 6, busy edges 3..5
    row(0, 1, 1, 4'b0000);
    row(0, 1, 1, 4'b0000);
    row(0, 1, 1, 4'b0001);
    row(0, 1, 1, 4'b0001);
    row(0, 1, 1, 4'b0001);
    row(0, 1, 1, 4'b1100);
    row(0, 1, 1, 4'b1000);
    row(0, 1, 1, 4'b1000);
    // clean fall
    row(0, 1, 0, 4'b1000);
    row(0, 1, 0, 4'b1000);
    row(0, 1, 0, 4'b1001);
    row(0, 1, 0, 4'b1001);
    row(0, 1, 0, 4'b1001);
    row(0, 1, 0, 4'b0010);
    row(0, 1, 0, 4'b0000);
    row(0, 1, 0, 4'b0000);
    // glitch: d_in high three cycles only reaches cnt=3
    row(0, 1, 1, 4'b0000);
    row(0, 1, 1, 4'b0000);
    row(0, 1, 1, 4'b0001);
    row(0, 1, 0, 4'b0001);
    row(0, 1, 0, 4'b0001);
    row(0, 1, 0, 4'b0000);
    row(0, 1, 0, 4'b0000);
    // enable on alternate edges
    row(0, 0, 1, 4'b0000);
    row(0, 1, 1, 4'b0000);
    row(0, 0, 1, 4'b0000);
    row(0, 1, 1, 4'b0001);
    row(0, 0, 1, 4'b0001);
    row(0, 1, 1, 4'b0001);
    row(0, 0, 1, 4'b0001);
    row(0, 1, 1, 4'b0001);
    row(0, 0, 1, 4'b0001);
    row(0, 1, 1, 4'b1100);
    row(0, 0, 1, 4'b1000);
    row(0, 1, 1, 4'b1000);
    // asynchronous reset from q=1
    async_rst();
    row(1, 1, 0, 4'b0000);
    row(0, 1, 1, 4'b0000);
    row(0, 1, 1, 4'b0000);
    row(0, 1, 1, 4'b0001);
    row(0, 1, 1, 4'b0001);
    // reset mid-count (cnt=2) with d_in held high
    async_rst();
    row(1, 1, 1, 4'b0000);
    row(1, 1, 1, 4'b0000);
    row(0, 1, 1, 4'b0000);
    row(0, 1, 1, 4'b0000);
    row(0, 1, 1, 4'b0001);
    row(0, 1, 1, 4'b0001);
    row(0, 1, 1, 4'b0001);
    row(0, 1, 1, 4'b1100);
    row(0, 1, 1, 4'b1000);
    repeat (3) @(negedge clk);
    done = 1'b1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sync_debounce.md
# sync_debounce

Input-conditioning stage that sits directly upstream of the `dff` data input. It takes a raw, asynchronous single-bit signal and passes it through a multi-flop synchronizer. It then debounces the signal with a stability counter and presents a clean registered level plus one-cycle edge pulses. Downstream flops and FSMs in the flip-flop practice set therefore never see metastable or bouncing inputs.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: number of synchronizer flops; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive enabled cycles of disagreement required before `q` changes; legal range ≥ 1.
- Counter width is fixed at `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `d_in` input 1: raw asynchronous input.
- `en` input 1: count enable / sample strobe; does not gate the synchronizer.
- `q` output 1: debounced level, registered.
- `rise` output 1: one-cycle pulse, registered, coincident with the cycle `q` first reads 1.
- `fall` output 1: one-cycle pulse, registered, coincident with the cycle `q` first reads 0.
- `busy` output 1: high while the stability counter is non-zero.

## Operation

- Synchronizer: a shift chain of `SYNC_STAGES` flops clocked every cycle. Its last stage, `s`, is the only signal used downstream.
- Two logical states, derived from the counter:
  - IDLE (`cnt == 0`)
  - COUNT (`cnt != 0`)
- Per rising edge with `en = 1`:
  - If `s == q`: `cnt <= 0` and return to IDLE. A glitch is discarded with no pulse.
  - If `s != q` and `cnt == DEBOUNCE_CYCLES-1`: `q <= ~q`, `cnt <= 0`. `rise <= ~q` and `fall <= q`, using the old `q`.
  - If `s != q` otherwise: `cnt <= cnt + 1`.
- Per rising edge with `en = 0`:
  - `cnt` and `q` hold.
  - `rise` and `fall` are forced to 0.
  - The synchronizer continues to shift.
- `rise` and `fall` default to 0 on every edge unless set by the toggle rule above. Each is never high for two consecutive cycles, and they are never high together.
- With `DEBOUNCE_CYCLES = 1`, `q` follows `s` one enabled edge later and `busy` is never asserted.
- `busy = (cnt != 0)`, decoded combinationally from the counter register.
- Counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap-around is possible.

## Timing

- Reset (`rst = 1`, asynchronous, immediate, independent of `clk`):
  - synchronizer chain = 0
  - `cnt` = 0
  - `q` = 0, `rise` = 0, `fall` = 0, `busy` = 0
- Reset release: first state update is at the first rising edge with `rst = 0`.
- Latency, with `en` held at 1 and `d_in` changed and held before edge 1 (edge 1 is the first edge that samples the new value):
  - `s` updates at edge `SYNC_STAGES`.
  - `q` toggles at edge `SYNC_STAGES + DEBOUNCE_CYCLES`; with defaults this is edge 6.
- `rise`/`fall` go high at the same edge as `q` toggles and clear at the next edge.
- `busy` rises at edge `SYNC_STAGES + 1` and falls at the toggle edge.
- Reset mid-count: all state clears at once. There is no residual pulse, and counting restarts from 0 after release.
- If `d_in = 1` is held through reset, `q` rises at edge `SYNC_STAGES + DEBOUNCE_CYCLES` after release, with a `rise` pulse.

## Test plan

1. Reset check: `rst = 1`, `d_in = 1`, `clk` toggling → `q`, `rise`, `fall`, `busy` all 0, with no change while `rst` is high. Also assert `rst` between clock edges → outputs go to 0 before the next edge.
2. Clean rise (defaults, `en = 1`): `d_in` 0→1 and held → `q` = 1 at edge 6; `rise` = 1 for exactly one cycle; `fall` stays 0; `busy` high from edge 3 through edge 5.
3. Glitch rejection: `d_in` high for 3 cycles, then low → `q` stays 0, no pulses, `busy` returns to 0 within 3 edges after `s` drops.
4. Clean fall: from `q = 1`, `d_in` 1→0 and held → `q` = 0 at edge 6; `fall` is a single-cycle pulse; `rise` stays 0.
5. Enable gating: `d_in` = 1 held, `en` high only on every other edge → `q` toggles only after 4 enabled edges with `s = 1`; `cnt` holds on disabled edges; no pulse on a disabled edge.
6. Reset mid-count: assert `rst` when `cnt = 2`, release with `d_in` still 1 → outputs clear immediately; `q` = 1 with a `rise` pulse exactly 6 edges after release.
